// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared types and constants for the regfile write arbiter
package regfile_write_arbiter_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_MEM = 1'b1
    } prio_state_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_write_arbiter_wb_slot.sv
// rtl/regfile_write_arbiter_wb_slot.sv - one-entry writeback holding slot with ready logic
module regfile_write_arbiter_wb_slot
    import regfile_write_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    in_valid,
    input  wb_req_t in_req,
    input  logic    grant,
    output logic    ready,
    output logic    full,
    output logic    load,
    output wb_req_t req
);

    slot_state_t state_q, state_d;
    wb_req_t     req_q, req_d;

    // Handshake and slot FSM: a granted slot can refill in the same cycle;
    // writes to register 0 are accepted but never stored.
    always_comb begin
        ready   = (state_q == EMPTY) || grant;
        load    = in_valid && ready && (in_req.addr != '0);
        state_d = state_q;
        req_d   = req_q;
        if (load) begin
            state_d = FULL;
            req_d   = in_req;
        end else if (grant) begin
            state_d = EMPTY;
        end
    end

    // Slot state and holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    assign full = (state_q == FULL);
    assign req  = req_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - arbitrates ALU and load writebacks onto the single regfile write port
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int ADDR_W       = RF_ADDR_W,
    parameter int DATA_W       = RF_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              rf_wr_en_n,
    input  logic [ADDR_W-1:0] q_addr0,
    input  logic [ADDR_W-1:0] q_addr1,
    output logic              q_pending0,
    output logic              q_pending1,
    output logic              grant_mem
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic    alu_full, mem_full, alu_load, mem_load;
    logic    gnt_alu, gnt_mem, both_full, same_addr;
    wb_req_t alu_req, mem_req;

    prio_state_t       prio_q, prio_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              mem_older_q, mem_older_d;
    logic [ADDR_W-1:0] rf_wr_addr_q, rf_wr_addr_d;
    logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;
    logic              rf_wr_en_n_q, rf_wr_en_n_d;
    logic              grant_mem_q, grant_mem_d;

    regfile_write_arbiter_wb_slot u_alu_slot (
        .clk      (clk),
        .rst_n    (rst),
        .in_valid (alu_valid),
        .in_req   ('{addr: alu_addr, data: alu_data}),
        .grant    (gnt_alu),
        .ready    (alu_ready),
        .full     (alu_full),
        .load     (alu_load),
        .req      (alu_req)
    );

    regfile_write_arbiter_wb_slot u_mem_slot (
        .clk      (clk),
        .rst_n    (rst),
        .in_valid (mem_valid),
        .in_req   ('{addr: mem_addr, data: mem_data}),
        .grant    (gnt_mem),
        .ready    (mem_ready),
        .full     (mem_full),
        .load     (mem_load),
        .req      (mem_req)
    );

    // Grant selection, starvation tracking, age tracking and output-stage next values.
    // Same-address ordering overrides priority so a younger write never lands first.
    always_comb begin
        both_full = alu_full && mem_full;
        same_addr = both_full && (alu_req.addr == mem_req.addr);
        gnt_alu   = 1'b0;
        gnt_mem   = 1'b0;
        if (both_full) begin
            gnt_mem = same_addr ? mem_older_q : (prio_q == PRIO_MEM);
            gnt_alu = !gnt_mem;
        end else begin
            gnt_alu = alu_full;
            gnt_mem = mem_full;
        end

        starve_cnt_d = '0;
        if (mem_full && gnt_alu) begin
            starve_cnt_d = (starve_cnt_q == CNT_MAX) ? starve_cnt_q : starve_cnt_q + 1'b1;
        end
        prio_d = (starve_cnt_d == CNT_MAX) ? PRIO_MEM : PRIO_ALU;

        // An ALU load alone or together with a mem load makes mem the older entry.
        mem_older_d = mem_older_q;
        if (alu_load) begin
            mem_older_d = 1'b1;
        end else if (mem_load) begin
            mem_older_d = 1'b0;
        end

        rf_wr_en_n_d = !(gnt_alu || gnt_mem);
        rf_wr_addr_d = rf_wr_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        grant_mem_d  = grant_mem_q;
        if (gnt_mem) begin
            rf_wr_addr_d = mem_req.addr;
            rf_wr_data_d = mem_req.data;
            grant_mem_d  = 1'b1;
        end else if (gnt_alu) begin
            rf_wr_addr_d = alu_req.addr;
            rf_wr_data_d = alu_req.data;
            grant_mem_d  = 1'b0;
        end
    end

    // Arbiter state and registered write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_q       <= PRIO_ALU;
            starve_cnt_q <= '0;
            mem_older_q  <= 1'b0;
            rf_wr_addr_q <= '0;
            rf_wr_data_q <= '0;
            rf_wr_en_n_q <= 1'b1;
            grant_mem_q  <= 1'b0;
        end else begin
            prio_q       <= prio_d;
            starve_cnt_q <= starve_cnt_d;
            mem_older_q  <= mem_older_d;
            rf_wr_addr_q <= rf_wr_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            rf_wr_en_n_q <= rf_wr_en_n_d;
            grant_mem_q  <= grant_mem_d;
        end
    end

    // Pending lookup covers both holding slots and the write currently on the port.
    always_comb begin
        q_pending0 = (q_addr0 != '0) &&
                     ((alu_full && (alu_req.addr == q_addr0)) ||
                      (mem_full && (mem_req.addr == q_addr0)) ||
                      (!rf_wr_en_n_q && (rf_wr_addr_q == q_addr0)));
        q_pending1 = (q_addr1 != '0) &&
                     ((alu_full && (alu_req.addr == q_addr1)) ||
                      (mem_full && (mem_req.addr == q_addr1)) ||
                      (!rf_wr_en_n_q && (rf_wr_addr_q == q_addr1)));
    end

    assign rf_wr_addr = rf_wr_addr_q;
    assign rf_wr_data = rf_wr_data_q;
    assign rf_wr_en_n = rf_wr_en_n_q;
    assign grant_mem  = grant_mem_q;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two writeback sources: ALU result (alu_*) and memory load (mem_*).
- Each source has a valid/ready handshake and a 1-entry holding slot. A fixed-priority arbiter with starvation escape selects which slot to drain.
- Drives the register file write port through registered outputs. Exposes pending-write lookups that decode uses for stall decisions.

Parameters:
ADDR_W, 5, register address width
DATA_W, 32, register data width
STARVE_LIMIT, 4, consecutive lost arbitration cycles after which the mem slot gets priority

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU slot can accept this cycle
alu_addr  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
mem_valid  in  1  load writeback request
mem_ready  out  1  mem slot can accept this cycle
mem_addr  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
rf_wr_addr  out  ADDR_W  register file write address
rf_wr_data  out  DATA_W  register file write data
rf_wr_en_n  out  1  register file write enable, active-low
q_addr0, q_addr1  in  ADDR_W  decode source-register lookups
q_pending0, q_pending1  out  1  lookup address has an uncommitted write
grant_mem  out  1  registered; 1 = current rf write came from mem slot

Behaviour:
- Reset (rst low, asynchronous):
  - both slots EMPTY; prio state PRIO_ALU; starve counter 0.
  - rf_wr_en_n=1, rf_wr_addr=0, rf_wr_data=0, grant_mem=0.
  - alu_ready=mem_ready=1 (combinational from slot state).
- Reset mid-operation discards slot contents and any in-flight write. No rf write occurs in the reset-release cycle.
- Handshake:
  - Transfer occurs on a rising edge where valid&ready=1.
  - ready = slot EMPTY, or slot FULL and granted this cycle (back-to-back, one transfer per cycle per source).
  - The source must hold addr/data stable while valid is high and ready is low.
- Address 0: a transfer with addr=0 is accepted and dropped. The slot stays EMPTY and no rf write is issued.
- Slot FSM per source:
  - EMPTY -> FULL on transfer with nonzero addr.
  - FULL -> EMPTY when granted without a new transfer.
  - FULL -> FULL when granted with a new transfer.
- Arbitration (combinational from slot state, cycle N):
  - Only one slot FULL: it is granted.
  - Both FULL in PRIO_ALU: ALU is granted, and the starve counter increments.
  - Counter reaching STARVE_LIMIT sets PRIO_MEM for the next cycle.
  - In PRIO_MEM, mem is granted; the counter clears and the state returns to PRIO_ALU.
  - The counter clears whenever the mem slot is granted or EMPTY.
- Same-address ordering: if both slots are FULL with equal addr, the slot loaded earlier is granted first, tracked by a 1-bit age flag. On equal load cycle, mem is granted first, since the ALU instruction is younger.
- Output stage:
  - The grant in cycle N registers into rf_wr_* and grant_mem, visible in cycle N+1. rf_wr_en_n is low for exactly that cycle.
  - No grant leaves rf_wr_en_n=1, with addr/data holding their previous values.
  - Accept-to-commit latency is 2 edges minimum: transfer at edge N, grant in N+1, rf_wr_en_n low in N+2, committed at the end of N+2.
- Pending lookup (combinational):
  - q_pendingX=1 if q_addrX matches a FULL slot addr, or matches rf_wr_addr while rf_wr_en_n=0.
  - q_addrX=0 always returns 0.
- Throughput: one rf write per cycle max. Sustained dual-source traffic serves mem at least once per STARVE_LIMIT+1 cycles.

Decomposition:
- Shared package: ADDR_W/DATA_W constants, prio_state enum {PRIO_ALU, PRIO_MEM}, slot_state enum {EMPTY, FULL}, and a wb_req struct {addr, data}.
- One sub-module, wb_slot: the holding register plus slot FSM plus ready logic, instantiated twice.

Test Plan:
- Reset then ALU writes addr=5 data=0xDEADBEEF -> rf_wr_en_n low 2 edges after the transfer, addr=5, data=0xDEADBEEF, grant_mem=0.
- ALU addr=0 data=0x1 -> accepted (alu_ready=1), rf_wr_en_n stays 1, q_pending0 with q_addr0=0 stays 0.
- Both valid continuously with distinct addrs -> ALU granted 4 consecutive cycles, mem on the 5th; pattern repeats; ready deasserts on mem while it waits.
- Same cycle, mem addr=7 data=0xA and ALU addr=7 data=0xB -> rf writes 0xA then 0xB on consecutive cycles; final reg7=0xB.
- Mem addr=3 accepted, q_addr1=3 -> q_pending1=1 from slot-full through the rf_wr_en_n-low cycle, 0 the cycle after.
- rst low while both slots FULL -> rf_wr_en_n=1 immediately (async); after release, both ready=1 and no stale write is issued.
